// File: rtl/riscv_core_sc.sv
// Single-cycle RV32I-subset core: combinational fetch/decode/execute, register file and data memory update on clk.
// Optional RV_MUL_EN adds MUL (funct7=0000001, funct3=000); without it that encoding runs as a NOP.
module riscv_core_sc #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input  logic clk,
  input  logic reset,
  output logic zero_flag
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL
  } alu_op_e;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rf_q   [32];
  logic [XLEN-1:0] imem_q [IMEM_DEPTH];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];

  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rs1_val, rs2_val;

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [4:0]      shamt;
  logic            rf_we, mem_we, is_load, is_branch, branch_ne, branch_taken;
  logic [XLEN-1:0] rf_wdata, dmem_rdata;
  logic [DMEM_AW-1:0] dmem_idx;

  // ROM image: every word starts as NOP.
  initial begin
    for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem_q[i] = NOP_INSTR;
  end

  assign instr  = imem_q[pc_q[IMEM_AW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  // Decode: anything not recognised falls through to the NOP defaults.
  always_comb begin
    alu_op    = ALU_ZERO;
    alu_a     = rs1_val;
    alu_b     = rs2_val;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    is_load   = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    unique case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          rf_we = 1'b1;
          unique case (funct3)
            3'b000: alu_op = ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = ALU_SRL;
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          rf_we  = 1'b1;
          alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          rf_we  = 1'b1;
          alu_op = ALU_SRA;
        end
`ifdef RV_MUL_EN
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          rf_we  = 1'b1;
          alu_op = ALU_MUL;
        end
`endif
      end
      OPC_I: begin
        alu_b = imm_i;
        unique case (funct3)
          3'b000: begin rf_we = 1'b1; alu_op = ALU_ADD; end
          3'b010: begin rf_we = 1'b1; alu_op = ALU_SLT; end
          3'b100: begin rf_we = 1'b1; alu_op = ALU_XOR; end
          3'b110: begin rf_we = 1'b1; alu_op = ALU_OR;  end
          3'b111: begin rf_we = 1'b1; alu_op = ALU_AND; end
          3'b001: begin
            if (funct7 == 7'b0000000) begin rf_we = 1'b1; alu_op = ALU_SLL; end
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin rf_we = 1'b1; alu_op = ALU_SRL; end
            else if (funct7 == 7'b0100000) begin rf_we = 1'b1; alu_op = ALU_SRA; end
          end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          alu_b   = imm_i;
          alu_op  = ALU_ADD;
          rf_we   = 1'b1;
          is_load = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          alu_b  = imm_s;
          alu_op = ALU_ADD;
          mem_we = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          alu_op    = ALU_SUB;
          is_branch = 1'b1;
          branch_ne = funct3[0];
        end
      end
      default: ;
    endcase
  end

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    unique case (alu_op)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(alu_a) >>> shamt);
      ALU_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
      ALU_MUL:  alu_result = alu_a * alu_b;
      default:  alu_result = '0;
    endcase
  end

  assign zero_flag    = (alu_result == '0);
  assign branch_taken = is_branch && (branch_ne ? !zero_flag : zero_flag);

  assign dmem_idx   = alu_result[DMEM_AW+1:2];
  assign dmem_rdata = dmem_q[dmem_idx];
  assign rf_wdata   = is_load ? dmem_rdata : alu_result;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (branch_taken) pc_d = pc_q + imm_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) dmem_q[dmem_idx] <= rs2_val;
  end

endmodule

// File: tb/tb_riscv_core_sc.sv
// Directed bench for riscv_core_sc: loads a short program into the ROM and checks PC, registers, memory and zero_flag.
module tb_riscv_core_sc;

  logic clk;
  logic reset;
  logic zero_flag;

  int tests;
  int fails;

  riscv_core_sc #(.IMEM_FILE("")) dut (
    .clk       (clk),
    .reset     (reset),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] mul_exp;
    logic [31:0] mul_zero_exp;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    #1;
    dut.imem_q[0]  = addi(5'd1, 5'd0, 12'd5);
    dut.imem_q[1]  = addi(5'd2, 5'd0, 12'd5);
    dut.imem_q[2]  = enc_r(7'b0100000, 3'b000, 5'd3, 5'd1, 5'd2);
    dut.imem_q[3]  = enc_r(7'b0000000, 3'b000, 5'd4, 5'd1, 5'd2);
    dut.imem_q[4]  = addi(5'd1, 5'd0, 12'h07F);
    dut.imem_q[5]  = enc_s(5'd0, 5'd1, 12'd8);
    dut.imem_q[6]  = enc_i(7'b0000011, 3'b010, 5'd5, 5'd0, 12'd8);
    dut.imem_q[7]  = addi(5'd6, 5'd0, 12'd3);
    dut.imem_q[8]  = enc_b(3'b000, 5'd6, 5'd6, 13'd8);
    dut.imem_q[9]  = addi(5'd7, 5'd0, 12'd1);
    dut.imem_q[10] = addi(5'd8, 5'd0, 12'd9);
    dut.imem_q[11] = addi(5'd0, 5'd0, 12'd7);
    dut.imem_q[12] = addi(5'd9, 5'd0, 12'hFFF);
    dut.imem_q[13] = addi(5'd9, 5'd9, 12'd1);
    dut.imem_q[14] = enc_b(3'b001, 5'd9, 5'd0, 13'd8);
    dut.imem_q[15] = addi(5'd10, 5'd0, 12'hFF8);
    dut.imem_q[16] = enc_i(7'b0010011, 3'b101, 5'd11, 5'd10, 12'h401);
    dut.imem_q[17] = enc_i(7'b0010011, 3'b101, 5'd12, 5'd10, 12'h01C);
    dut.imem_q[18] = enc_r(7'b0000000, 3'b011, 5'd13, 5'd0, 5'd10);
    dut.imem_q[19] = enc_r(7'b0000000, 3'b010, 5'd14, 5'd10, 5'd0);
    dut.imem_q[20] = 32'hFFFF_FFFF;
    dut.imem_q[21] = enc_r(7'b0000001, 3'b000, 5'd15, 5'd1, 5'd5);

`ifdef RV_MUL_EN
    mul_exp      = 32'h0000_3F01;
    mul_zero_exp = 32'd0;
`else
    mul_exp      = 32'd0;
    mul_zero_exp = 32'd1;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", dut.pc_q, 32'd0);
    check("reset_x1", dut.rf_q[1], 32'd0);
    check("reset_x31", dut.rf_q[31], 32'd0);
    check("reset_zero_addi5", {31'd0, zero_flag}, 32'd0);
    reset = 1'b1;

    step();
    check("addi_x1", dut.rf_q[1], 32'd5);
    step();
    check("addi_x2", dut.rf_q[2], 32'd5);
    check("sub_zero", {31'd0, zero_flag}, 32'd1);
    step();
    check("sub_x3", dut.rf_q[3], 32'd0);
    check("add_zero", {31'd0, zero_flag}, 32'd0);
    step();
    check("add_x4", dut.rf_q[4], 32'd10);
    step();
    check("addi_x1_7f", dut.rf_q[1], 32'h7F);
    check("sw_zero", {31'd0, zero_flag}, 32'd0);
    step();
    check("sw_dmem2", dut.dmem_q[2], 32'h7F);
    step();
    check("lw_x5", dut.rf_q[5], 32'h7F);
    step();
    check("beq_pc", dut.pc_q, 32'd32);
    check("beq_x6", dut.rf_q[6], 32'd3);
    check("beq_zero", {31'd0, zero_flag}, 32'd1);
    step();
    check("beq_target_pc", dut.pc_q, 32'd40);
    step();
    check("skip_x7", dut.rf_q[7], 32'd0);
    check("after_x8", dut.rf_q[8], 32'd9);
    step();
    check("x0_stays_zero", dut.rf_q[0], 32'd0);
    step();
    check("addi_neg1", dut.rf_q[9], 32'hFFFF_FFFF);
    check("wrap_zero", {31'd0, zero_flag}, 32'd1);
    step();
    check("wrap_x9", dut.rf_q[9], 32'd0);
    check("bne_zero", {31'd0, zero_flag}, 32'd1);
    step();
    check("bne_not_taken_pc", dut.pc_q, 32'd60);
    step();
    check("addi_neg8", dut.rf_q[10], 32'hFFFF_FFF8);
    step();
    check("srai_x11", dut.rf_q[11], 32'hFFFF_FFFC);
    step();
    check("srli_x12", dut.rf_q[12], 32'h0000_000F);
    step();
    check("sltu_x13", dut.rf_q[13], 32'd1);
    step();
    check("slt_x14", dut.rf_q[14], 32'd1);
    check("unsup_zero", {31'd0, zero_flag}, 32'd1);
    step();
    check("unsup_pc", dut.pc_q, 32'd84);
    check("unsup_x31", dut.rf_q[31], 32'd0);
    check("mul_zero", {31'd0, zero_flag}, mul_zero_exp);
    step();
    check("mul_x15", dut.rf_q[15], mul_exp);

    #2;
    reset = 1'b0;
    #1;
    check("async_pc", dut.pc_q, 32'd0);
    check("async_x1", dut.rf_q[1], 32'd0);
    check("async_x5", dut.rf_q[5], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check("restart_pc", dut.pc_q, 32'd0);
    step();
    check("restart_x1", dut.rf_q[1], 32'd5);
    check("restart_pc4", dut.pc_q, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
